mult_share_arbiter: RTL and testbench

Shares one signed `SignedMultiplier` instance among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, round-robin by default. It pipelines the product through a stallable pipeline and returns the result tagged with the requester index on a single result port. It sits between the NTT/butterfly-side requesters and the shared DSP multiplier.

---
 rtl/mult_share_arbiter.sv | 134 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin share of one signed multiplier across NUM_REQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

module signed_multiplier #(
  parameter int W = 24
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  logic signed [2*W-1:0] ax, bx;

  // Sign-extend to full product width so the low 2W bits are the exact signed product.
  assign ax = {{W{a[W-1]}}, a};
  assign bx = {{W{b[W-1]}}, b};
  assign p  = ax * bx;
endmodule

module mult_share_arbiter #(
  parameter int WIDTH_IN   = 24,
  parameter int NUM_REQ    = 4,
  parameter int PIPE_EXTRA = 0,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  output logic [ID_W-1:0]              res_id,
  output logic [2*WIDTH_IN-1:0]        res_p,
  input  logic                         res_ready,
  output logic                         busy
);
  localparam int NS = PIPE_EXTRA + 1;

  logic                  advance;
  logic                  xfer;
  logic                  found;
  int                    idx;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gidx;
  logic [ID_W-1:0]       ptr;

  logic                  s0_v;
  logic [ID_W-1:0]       s0_id;
  logic [WIDTH_IN-1:0]   s0_a;
  logic [WIDTH_IN-1:0]   s0_b;
  logic [2*WIDTH_IN-1:0] prod;

  // st_*[0] is the product register; the rest are the optional extra stages.
  logic [NS-1:0]         st_v;
  logic [ID_W-1:0]       st_id [NS];
  logic [2*WIDTH_IN-1:0] st_p  [NS];

  assign res_valid = st_v[NS-1];
  assign res_id    = st_id[NS-1];
  assign res_p     = st_p[NS-1];
  assign advance   = !res_valid || res_ready;
  assign busy      = s0_v || (|st_v);

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr;

  assign ptr = rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end
`endif

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = ID_W'(idx);
      end
    end
  end

  assign req_ready = (advance && !rst) ? grant : '0;
  assign xfer      = |req_ready;

  signed_multiplier #(.W(WIDTH_IN)) u_mul (
    .a (s0_a),
    .b (s0_b),
    .p (prod)
  );

  // The whole pipeline moves in lockstep on advance, so ordering is preserved under stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v  <= 1'b0;
      s0_id <= '0;
      s0_a  <= '0;
      s0_b  <= '0;
      st_v  <= '0;
      for (int k = 0; k < NS; k++) begin
        st_id[k] <= '0;
        st_p[k]  <= '0;
      end
    end else if (advance) begin
      s0_v <= xfer;
      if (xfer) begin
        s0_id <= gidx;
        s0_a  <= req_a[int'(gidx)*WIDTH_IN +: WIDTH_IN];
        s0_b  <= req_b[int'(gidx)*WIDTH_IN +: WIDTH_IN];
      end
      st_v[0]  <= s0_v;
      st_id[0] <= s0_id;
      st_p[0]  <= prod;
      for (int k = 1; k < NS; k++) begin
        st_v[k]  <= st_v[k-1];
        st_id[k] <= st_id[k-1];
        st_p[k]  <= st_p[k-1];
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed self-checking bench for mult_share_arbiter (PIPE_EXTRA 0 and 2).

module tb_mult_share_arbiter;
  localparam int W = 24;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, req_ready2;
  logic           res_valid, res_valid2;
  logic           res_ready, res_ready2;
  logic [1:0]     res_id, res_id2;
  logic [2*W-1:0] res_p, res_p2;
  logic           busy, busy2;

  int checks   = 0;
  int failures = 0;

  longint         op_a [N];
  longint         op_b [N];
  logic [1:0]     q_id [$];
  logic [2*W-1:0] q_p  [$];

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH_IN(W), .NUM_REQ(N), .PIPE_EXTRA(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_p(res_p),
    .res_ready(res_ready), .busy(busy)
  );

  mult_share_arbiter #(.WIDTH_IN(W), .NUM_REQ(N), .PIPE_EXTRA(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready2), .res_valid(res_valid2), .res_id(res_id2), .res_p(res_p2),
    .res_ready(res_ready2), .busy(busy2)
  );

  task automatic set_op(input int i, input longint a, input longint b);
    op_a[i] = a;
    op_b[i] = b;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    res_ready  = 1'b1;
    res_ready2 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'hf;
    req_a      = '0;
    req_b      = '0;
    res_ready  = 1'b1;
    res_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
    checks++; if (res_p !== 48'd0) begin failures++; $display("FAIL reset_res_p got=%0h exp=0", res_p); end
    checks++; if (busy !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy, busy2); end
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    set_op(2, 3, -5);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", res_valid); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", res_id); end
    checks++; if (res_p !== 48'(-64'sd15)) begin failures++; $display("FAIL single_p got=%0d exp=-15", $signed(res_p)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0]   exp_g;
    int             exp_id;
    logic [2*W-1:0] exp_p;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, longint'(i + 1), -longint'(3 * i + 2));
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_g  = (c < 8) ? 4'b0001 : 4'b0000;
      exp_id = 0;
`else
      exp_g  = (c < 8) ? 4'(1 << (c % N)) : 4'b0000;
      exp_id = (c - 2 + N) % N;
`endif
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
      if (c >= 2) begin
        exp_p = 48'(op_a[exp_id] * op_b[exp_id]);
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL rr_valid c=%0d got=%b exp=1", c, res_valid); end
        checks++; if (res_id !== 2'(exp_id)) begin failures++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, res_id, exp_id); end
        checks++; if (res_p !== exp_p) begin failures++; $display("FAIL rr_p c=%0d got=%0h exp=%0h", c, res_p, exp_p); end
      end
      @(posedge clk);
      #1;
      if (c == 7) req_valid = '0;
    end
  endtask

  task automatic test_extremes();
    do_reset();
    set_op(0, -64'sd8388608, -64'sd8388608);
    set_op(1, 64'sd8388607, -64'sd8388608);
    req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (res_p !== 48'd70368744177664) begin failures++; $display("FAIL ext_minmin got=%0d exp=70368744177664", $signed(res_p)); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL ext_minmin_id got=%0d exp=0", res_id); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (res_p !== 48'(-64'sd70368735789056)) begin failures++; $display("FAIL ext_maxmin got=%0d exp=-70368735789056", $signed(res_p)); end
    checks++; if (res_id !== 2'd1) begin failures++; $display("FAIL ext_maxmin_id got=%0d exp=1", res_id); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int             sent = 0;
    int             got  = 0;
    logic [1:0]     hold_id;
    logic [2*W-1:0] hold_p;
    logic [N-1:0]   exp_g;
    do_reset();
    q_id.delete();
    q_p.delete();
    set_op(1, -3000, 1);
    req_valid = 4'b0010;
    for (int c = 0; c < 40 && got < 8; c++) begin
      res_ready = !(c >= 4 && c <= 8);
      @(negedge clk);
      if (res_ready) begin
        exp_g = (sent < 8) ? 4'b0010 : 4'b0000;
        checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_grant c=%0d got=%b exp=0000", c, req_ready); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_valid c=%0d got=%b exp=1", c, res_valid); end
        if (c == 4) begin
          hold_id = res_id;
          hold_p  = res_p;
        end else begin
          checks++; if (res_id !== hold_id || res_p !== hold_p) begin failures++; $display("FAIL bp_stall_hold c=%0d got=%0d/%0h exp=%0d/%0h", c, res_id, res_p, hold_id, hold_p); end
        end
      end
      if (req_valid[1] && req_ready[1]) begin
        q_id.push_back(2'd1);
        q_p.push_back(48'(op_a[1] * op_b[1]));
        sent++;
      end
      if (res_valid && res_ready) begin
        checks++;
        if (q_p.size() == 0) begin
          failures++; $display("FAIL bp_extra_result c=%0d got=%0h exp=none", c, res_p);
        end else begin
          if (res_id !== q_id[0] || res_p !== q_p[0]) begin failures++; $display("FAIL bp_order c=%0d got=%0d/%0h exp=%0d/%0h", c, res_id, res_p, q_id[0], q_p[0]); end
          q_id.pop_front();
          q_p.pop_front();
          got++;
        end
      end
      @(posedge clk);
      #1;
      if (sent < 8) set_op(1, longint'(1000 * sent - 3000), longint'(7 * sent + 1));
      else req_valid = '0;
    end
    checks++; if (got !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b%b exp=00", res_valid, busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    res_ready2 = 1'b0;
    set_op(3, 11, 13);
    req_valid = 4'b1000;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (res_valid2 !== 1'b1 || busy2 !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b%b exp=11", res_valid2, busy2); end
    checks++; if (res_p2 !== 48'd143) begin failures++; $display("FAIL mid_pre_p got=%0d exp=143", res_p2); end
    @(posedge clk);
    #1 req_valid = 4'b1000;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (res_valid2 !== 1'b0 || res_id2 !== 2'd0 || res_p2 !== 48'd0) begin failures++; $display("FAIL mid_async_clear got=%b/%0d/%0h exp=0/0/0", res_valid2, res_id2, res_p2); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL mid_async_busy got=%b exp=0", busy2); end
    checks++; if (req_ready2 !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready2); end
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid  = '0;
    res_ready2 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (res_valid2 !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d got=%b exp=0", c, res_valid2); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_pipe_extra();
    do_reset();
    set_op(1, -7, 6);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready2 !== 4'b0010) begin failures++; $display("FAIL pe_grant got=%b exp=0010", req_ready2); end
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        checks++; if (res_valid2 !== 1'b0) begin failures++; $display("FAIL pe_early c=%0d got=%b exp=0", c, res_valid2); end
      end else begin
        checks++; if (res_valid2 !== 1'b1) begin failures++; $display("FAIL pe_valid got=%b exp=1", res_valid2); end
        checks++; if (res_id2 !== 2'd1 || res_p2 !== 48'(-64'sd42)) begin failures++; $display("FAIL pe_result got=%0d/%0d exp=1/-42", res_id2, $signed(res_p2)); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_back_to_back();
    test_reset_mid_stall();
    test_pipe_extra();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
